point_generator: RTL and testbench

POINT_GENERATOR -- requirements
Module: point_generator

---
 rtl/point_gen_pkg.sv | 18 +
 rtl/point_gen_fxmul.sv | 17 +
 rtl/point_generator.sv | 154 +++++++++++++++
 tb/tb_point_generator.sv | 132 +++++++++++++
 4 files changed

// File: rtl/point_gen_pkg.sv
// Shared types and constants for the fixed-point escape-time point generator.
// The CHECK state only exists when POINT_GEN_BULB_CHECK_EN is defined.
package point_gen_pkg;

  localparam int FRAC_DEF = 24;
  localparam logic [63:0] FOUR = 64'd4 << FRAC_DEF;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ITER,
    DONE
`ifdef POINT_GEN_BULB_CHECK_EN
    , CHECK
`endif
  } state_t;

endpackage

// File: rtl/point_gen_fxmul.sv
// Signed HBP x HBP multiplier; shift=1 returns the product >>> FRAC, shift=0 the raw product.
module point_gen_fxmul #(
  parameter int HBP  = 32,
  parameter int FRAC = 24
) (
  input  logic signed [HBP-1:0]   a,
  input  logic signed [HBP-1:0]   b,
  input  logic                    shift,
  output logic signed [2*HBP-1:0] p
);

  logic signed [2*HBP-1:0] full;

  assign full = (2*HBP)'(a) * (2*HBP)'(b);
  assign p    = shift ? (full >>> FRAC) : full;

endmodule

// File: rtl/point_generator.sv
// Escape-time iteration of z' = z^2 + c for one pixel, Q.FRAC fixed point.
// Optional cardioid/bulb pre-check enabled by POINT_GEN_BULB_CHECK_EN.
module point_generator
  import point_gen_pkg::*;
#(
  parameter int HBP  = 32,
  parameter int HBS  = 32,
  parameter int HBI  = 32,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [HBS-1:0]        re_scale,
  input  logic [HBS-1:0]        im_scale,
  input  logic [11:0]           x,
  input  logic [11:0]           y,
  input  logic [HBI-1:0]        max_iterations,
  input  logic signed [HBP-1:0] re_start,
  input  logic signed [HBP-1:0] im_start,
  output logic                  ready,
  output logic [HBI-1:0]        iteration
);

  // Escape threshold compared against the unshifted (Q.2FRAC) sum of squares.
  localparam logic signed [2*HBP:0] FOUR_SQ = (2*HBP+1)'(FOUR >> FRAC_DEF) << (2*FRAC);

  state_t state, next_state;

  logic [11:0]           x_q, y_q;
  logic [HBS-1:0]        re_scale_q, im_scale_q;
  logic signed [HBP-1:0] re_start_q, im_start_q;
  logic [HBI-1:0]        max_q, count, iteration_q;
  logic signed [HBP-1:0] c_re, c_im, zr, zi;

  logic signed [HBP-1:0]   a0, b0, a1, b1, a2, b2;
  logic signed [2*HBP-1:0] p0, p1, p2;
  logic signed [2*HBP:0]   mag2;
  logic                    stop;

  // Squares stay unshifted so the escape test sees full precision.
  point_gen_fxmul #(.HBP(HBP), .FRAC(FRAC)) u_mul_rr (.a(a0), .b(b0), .shift(1'b0), .p(p0));
  point_gen_fxmul #(.HBP(HBP), .FRAC(FRAC)) u_mul_ii (.a(a1), .b(b1), .shift(1'b0), .p(p1));
  point_gen_fxmul #(.HBP(HBP), .FRAC(FRAC)) u_mul_ri (.a(a2), .b(b2), .shift(1'b1), .p(p2));

`ifdef POINT_GEN_BULB_CHECK_EN
  localparam logic signed [HBP-1:0] QUARTER   = HBP'(1) << (FRAC - 2);
  localparam logic signed [HBP-1:0] ONE       = HBP'(1) << FRAC;
  localparam logic signed [HBP-1:0] SIXTEENTH = HBP'(1) << (FRAC - 4);

  logic signed [HBP-1:0]   t, u;
  logic signed [2*HBP-1:0] q, card;
  logic signed [4*HBP-1:0] lhs, rhs;
  logic                    in_bulb;

  assign t    = c_re - QUARTER;
  assign u    = c_re + ONE;
  assign q    = (p0 >>> FRAC) + (p1 >>> FRAC);
  // Both sides in Q.2FRAC: q*(q+t) against c_im^2/4.
  assign lhs  = (4*HBP)'(q) * (4*HBP)'(q + (2*HBP)'(t));
  assign rhs  = (4*HBP)'(p1 >>> 2);
  assign card = p2 + (p1 >>> FRAC);
  assign in_bulb = (lhs <= rhs) || (card <= (2*HBP)'(SIXTEENTH));
`endif

  always_comb begin
    a0 = zr; b0 = zr;
    a1 = zi; b1 = zi;
    a2 = zr; b2 = zi;
    case (state)
      SETUP: begin
        a0 = HBP'(x_q); b0 = HBP'(re_scale_q);
        a1 = HBP'(y_q); b1 = HBP'(im_scale_q);
      end
`ifdef POINT_GEN_BULB_CHECK_EN
      CHECK: begin
        a0 = t;    b0 = t;
        a1 = c_im; b1 = c_im;
        a2 = u;    b2 = u;
      end
`endif
      default: ;
    endcase
  end

  assign mag2 = (2*HBP+1)'(p0) + (2*HBP+1)'(p1);
  assign stop = (count == max_q) || (mag2 > FOUR_SQ);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (start) next_state = SETUP;
    else begin
      case (state)
`ifdef POINT_GEN_BULB_CHECK_EN
        SETUP:   next_state = CHECK;
        CHECK:   next_state = ITER;
`else
        SETUP:   next_state = ITER;
`endif
        ITER:    if (stop) next_state = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count       <= '0;
      zr          <= '0;
      zi          <= '0;
      iteration_q <= '0;
    end else if (start) begin
      x_q        <= x;
      y_q        <= y;
      re_scale_q <= re_scale;
      im_scale_q <= im_scale;
      re_start_q <= re_start;
      im_start_q <= im_start;
      max_q      <= max_iterations;
    end else begin
      case (state)
        SETUP: begin
          c_re  <= re_start_q + HBP'(p0);
          c_im  <= im_start_q + HBP'(p1);
          zr    <= '0;
          zi    <= '0;
          count <= '0;
        end
`ifdef POINT_GEN_BULB_CHECK_EN
        // Inside the bulb: preload the limit so the first ITER cycle terminates.
        CHECK: if (in_bulb) count <= max_q;
`endif
        ITER: begin
          if (stop) iteration_q <= count;
          else begin
            zr    <= HBP'(p0 >>> FRAC) - HBP'(p1 >>> FRAC) + c_re;
            zi    <= (HBP'(p2) <<< 1) + c_im;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state == IDLE) || (state == DONE);
  assign iteration = iteration_q;

endmodule

// File: tb/tb_point_generator.sv
// Directed bench for point_generator (Q8.24 defaults); latencies track POINT_GEN_BULB_CHECK_EN.
module tb_point_generator;

`ifdef POINT_GEN_BULB_CHECK_EN
  localparam int XL = 1;
  localparam bit BULB = 1'b1;
`else
  localparam int XL = 0;
  localparam bit BULB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] re_scale = '0, im_scale = '0;
  logic [11:0] x = '0, y = '0;
  logic [31:0] max_iterations = '0;
  logic [31:0] re_start = '0, im_start = '0;
  logic        ready;
  logic [31:0] iteration;

  int vectors = 0;
  int miscompares = 0;

  point_generator dut (
    .CLK(CLK), .RST(RST), .start(start), .re_scale(re_scale), .im_scale(im_scale),
    .x(x), .y(y), .max_iterations(max_iterations), .re_start(re_start),
    .im_start(im_start), .ready(ready), .iteration(iteration)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one start; returns #1 after the sampling edge T.
  task automatic go(input logic [31:0] rs, input logic [31:0] is, input logic [31:0] rsc,
                    input logic [31:0] isc, input logic [11:0] px, input logic [11:0] py,
                    input logic [31:0] mx);
    @(negedge CLK);
    re_start = rs; im_start = is; re_scale = rsc; im_scale = isc;
    x = px; y = py; max_iterations = mx; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  // Latency is counted in edges after T; -1 flags an expired bound.
  task automatic run(input string tag, input int exp_it, input int exp_lat);
    int k = 0;
    bit seen = 1'b0;
    chk({tag, "_busy"}, ready, 0);
    while (k < 400 && !seen) begin
      @(posedge CLK); #1;
      k++;
      seen = ready;
    end
    chk({tag, "_lat"}, seen ? k : -1, exp_lat);
    chk({tag, "_it"}, iteration, exp_it);
  endtask

  initial begin
    bit bad;
    // Reset with start held high: reset must win.
    start = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_iter", iteration, 0);
    @(negedge CLK); start = 1'b0; RST = 1'b0;

    go(32'h0200_0000, 32'h0200_0000, 0, 0, 0, 0, 255);
    run("c2_2", 1, 3 + XL);

    go(32'hFE00_0000, 0, 32'h0100_0000, 0, 3, 0, 255);
    run("c1_0", 3, 5 + XL);

    go(0, 0, 0, 0, 0, 0, 255);
    run("c0", 255, BULB ? 3 : 257);

    go(32'hFF00_0000, 0, 0, 0, 0, 0, 20);
    run("cm1", 20, BULB ? 3 : 22);

    go(32'h0200_0000, 32'h0200_0000, 0, 0, 0, 0, 0);
    run("max0", 0, 2 + XL);

    // c = 0 + 2*0.5, -1 + 4*0.25 = (1,0) through both scale products
    go(0, 32'hFF00_0000, 32'h0080_0000, 32'h0040_0000, 2, 4, 255);
    run("scaled", 3, 5 + XL);

    // |z|^2 == 4 exactly must not escape
    go(32'h0200_0000, 0, 0, 0, 0, 0, 255);
    run("c2_0", 2, 4 + XL);

    go(32'hFE00_0000, 0, 0, 0, 0, 0, 10);
    run("cm2", 10, 12 + XL);

    repeat (5) @(posedge CLK);
    #1;
    chk("hold_ready", ready, 1);
    chk("hold_iter", iteration, 10);

    // Reset at T+2 of a c=0 run
    go(0, 0, 0, 0, 0, 0, 255);
    @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_iter", iteration, 0);
    @(negedge CLK); RST = 1'b0;
    bad = 1'b0;
    repeat (300) begin
      @(posedge CLK); #1;
      if (!ready || iteration != 0) bad = 1'b1;
    end
    chk("midrst_quiet", bad, 0);

    // Restart at T+2 with c=(2,2) during a c=0 run
    go(0, 0, 0, 0, 0, 0, 255);
    @(posedge CLK);
    go(32'h0200_0000, 32'h0200_0000, 0, 0, 0, 0, 255);
    run("restart", 1, 3 + XL);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
